// File: rtl/riscv_irq_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package riscv_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_VECTOR,
    ST_HANDLER,
    ST_RESTORE,
    ST_RESUME
  } irq_state_t;

  localparam int          MCAUSE_INT_BIT      = 63;
  localparam int          IRQ_ID_W            = 4;
  localparam logic [63:0] DEFAULT_VECTOR_BASE = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest-numbered active request line wins.
module irq_priority_encoder
  import riscv_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  i_req,
  output logic [IRQ_ID_W-1:0] o_id,
  output logic                o_valid
);

  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    // Scan from the top down so the last hit is the lowest index.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = IRQ_ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: drain, GPR save walk, vector, handler,
// GPR restore walk and resume. Every output is a register.
module interrupt_sequencer
  import riscv_irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [63:0] VECTOR_BASE = DEFAULT_VECTOR_BASE,
  parameter int          NUM_SAVE    = 31
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               irq_enable_in,
  input  logic               mret_in,
  input  logic               stall_in,
  input  logic [63:0]        pc_in,
  output logic               interrupt_signal_out,
  output logic               return_interrupt_signal_out,
  output logic [4:0]         register_addres_out,
  output logic               flush_signal_out,
  output logic               stall_signal_out,
  output logic               pc_load_out,
  output logic [63:0]        pc_target_out,
  output logic [63:0]        csr_mepc_out,
  output logic [63:0]        mcause_out,
  output logic [NUM_IRQ-1:0] irq_ack_out,
  output logic               busy_out
);

  localparam logic [4:0] LAST_ADDR = 5'(NUM_SAVE);

  logic [IRQ_ID_W-1:0] w_irq_id;
  logic                w_irq_valid;

  irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req   (irq_in),
    .o_id    (w_irq_id),
    .o_valid (w_irq_valid)
  );

  irq_state_t          r_state, w_state_nxt;
  logic [IRQ_ID_W-1:0] r_id, w_id_nxt;
  logic [4:0]          r_addr, w_addr_nxt;
  logic                r_int, w_int_nxt;
  logic                r_ret, w_ret_nxt;
  logic                r_flush, w_flush_nxt;
  logic                r_stall, w_stall_nxt;
  logic                r_pc_load, w_pc_load_nxt;
  logic [63:0]         r_pc_target, w_pc_target_nxt;
  logic [63:0]         r_mepc, w_mepc_nxt;
  logic [63:0]         r_mcause, w_mcause_nxt;
  logic [NUM_IRQ-1:0]  r_ack, w_ack_nxt;
  logic                r_busy, w_busy_nxt;

  // Outputs are decoded from the next state so they line up with r_state.
  always_comb begin
    w_state_nxt     = r_state;
    w_id_nxt        = r_id;
    w_addr_nxt      = '0;
    w_int_nxt       = 1'b0;
    w_ret_nxt       = 1'b0;
    w_flush_nxt     = 1'b0;
    w_stall_nxt     = 1'b0;
    w_pc_load_nxt   = 1'b0;
    w_pc_target_nxt = '0;
    w_mepc_nxt      = r_mepc;
    w_mcause_nxt    = r_mcause;
    w_ack_nxt       = '0;

    case (r_state)
      ST_IDLE: begin
        if (irq_enable_in && w_irq_valid) begin
          w_state_nxt = ST_DRAIN;
          w_id_nxt    = w_irq_id;
          w_flush_nxt = 1'b1;
          w_stall_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stall_in) begin
          w_flush_nxt = 1'b1;
          w_stall_nxt = 1'b1;
        end else begin
          w_state_nxt                  = ST_SAVE;
          w_mepc_nxt                   = pc_in;
          w_mcause_nxt                 = '0;
          w_mcause_nxt[MCAUSE_INT_BIT] = 1'b1;
          w_mcause_nxt[IRQ_ID_W-1:0]   = r_id;
          w_int_nxt                    = 1'b1;
          w_stall_nxt                  = 1'b1;
          w_addr_nxt                   = 5'd1;
        end
      end
      ST_SAVE: begin
        // Compare before incrementing so the 5-bit walk never wraps.
        if (r_addr == LAST_ADDR) begin
          w_state_nxt     = ST_VECTOR;
          w_pc_load_nxt   = 1'b1;
          w_pc_target_nxt = VECTOR_BASE + 64'({r_id, 2'b00});
          for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_nxt[i] = (r_id == IRQ_ID_W'(i));
          end
        end else begin
          w_int_nxt   = 1'b1;
          w_stall_nxt = 1'b1;
          w_addr_nxt  = r_addr + 5'd1;
        end
      end
      ST_VECTOR: w_state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        if (mret_in) begin
          w_state_nxt = ST_RESTORE;
          w_ret_nxt   = 1'b1;
          w_stall_nxt = 1'b1;
          w_flush_nxt = 1'b1;
          w_addr_nxt  = 5'd1;
        end
      end
      ST_RESTORE: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nxt     = ST_RESUME;
          w_pc_load_nxt   = 1'b1;
          w_pc_target_nxt = r_mepc;
        end else begin
          w_ret_nxt   = 1'b1;
          w_stall_nxt = 1'b1;
          w_addr_nxt  = r_addr + 5'd1;
        end
      end
      ST_RESUME: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_int       <= 1'b0;
      r_ret       <= 1'b0;
      r_flush     <= 1'b0;
      r_stall     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_addr      <= w_addr_nxt;
      r_int       <= w_int_nxt;
      r_ret       <= w_ret_nxt;
      r_flush     <= w_flush_nxt;
      r_stall     <= w_stall_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_pc_target <= w_pc_target_nxt;
      r_mepc      <= w_mepc_nxt;
      r_mcause    <= w_mcause_nxt;
      r_ack       <= w_ack_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign interrupt_signal_out        = r_int;
  assign return_interrupt_signal_out = r_ret;
  assign register_addres_out         = r_addr;
  assign flush_signal_out            = r_flush;
  assign stall_signal_out            = r_stall;
  assign pc_load_out                 = r_pc_load;
  assign pc_target_out               = r_pc_target;
  assign csr_mepc_out                = r_mepc;
  assign mcause_out                  = r_mcause;
  assign irq_ack_out                 = r_ack;
  assign busy_out                    = r_busy;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: scripted per-interrupt phase
// traces with randomized side inputs, compared against a transaction model.
module tb_interrupt_sequencer;

  localparam int          NUM_IRQ  = 4;
  localparam int          NUM_SAVE = 31;
  localparam logic [63:0] VB       = 64'h0000_0000_0000_0100;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_enable_in;
  logic               mret_in;
  logic               stall_in;
  logic [63:0]        pc_in;
  logic               interrupt_signal_out;
  logic               return_interrupt_signal_out;
  logic [4:0]         register_addres_out;
  logic               flush_signal_out;
  logic               stall_signal_out;
  logic               pc_load_out;
  logic [63:0]        pc_target_out;
  logic [63:0]        csr_mepc_out;
  logic [63:0]        mcause_out;
  logic [NUM_IRQ-1:0] irq_ack_out;
  logic               busy_out;

  interrupt_sequencer #(.NUM_IRQ(NUM_IRQ), .VECTOR_BASE(VB), .NUM_SAVE(NUM_SAVE)) dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .irq_in                      (irq_in),
    .irq_enable_in               (irq_enable_in),
    .mret_in                     (mret_in),
    .stall_in                    (stall_in),
    .pc_in                       (pc_in),
    .interrupt_signal_out        (interrupt_signal_out),
    .return_interrupt_signal_out (return_interrupt_signal_out),
    .register_addres_out         (register_addres_out),
    .flush_signal_out            (flush_signal_out),
    .stall_signal_out            (stall_signal_out),
    .pc_load_out                 (pc_load_out),
    .pc_target_out               (pc_target_out),
    .csr_mepc_out                (csr_mepc_out),
    .mcause_out                  (mcause_out),
    .irq_ack_out                 (irq_ack_out),
    .busy_out                    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_mepc   = '0;
  logic [63:0] m_mcause = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int lowest_set(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic expect_out(input string ph, input bit fl, input bit st, input bit sv,
                            input bit rs, input int addr, input bit ld,
                            input logic [63:0] tgt, input int ack, input bit busy);
    check({ph, ".flush"},  64'(flush_signal_out),            64'(fl));
    check({ph, ".stall"},  64'(stall_signal_out),            64'(st));
    check({ph, ".save"},   64'(interrupt_signal_out),        64'(sv));
    check({ph, ".rest"},   64'(return_interrupt_signal_out), 64'(rs));
    check({ph, ".addr"},   64'(register_addres_out),         64'(addr));
    check({ph, ".pcld"},   64'(pc_load_out),                 64'(ld));
    if (ld) check({ph, ".target"}, pc_target_out, tgt);
    check({ph, ".ack"},    64'(irq_ack_out),                 64'(ack));
    check({ph, ".busy"},   64'(busy_out),                    64'(busy));
    check({ph, ".mepc"},   csr_mepc_out,                     m_mepc);
    check({ph, ".mcause"}, mcause_out,                       m_mcause);
  endtask

  task automatic expect_idle(input string ph);
    expect_out(ph, 0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic drive_noise();
    irq_in        = NUM_IRQ'($urandom);
    irq_enable_in = 1'($urandom);
    stall_in      = 1'($urandom);
    mret_in       = 1'($urandom);
    pc_in         = {$urandom, $urandom};
  endtask

  // One full interrupt; the DUT must be in IDLE on entry. With noise=0 the
  // request and enable stay at their initial values for the whole sequence.
  task automatic run_irq(input logic [NUM_IRQ-1:0] irq, input int stall_len,
                         input int handler_len, input bit noise, input int abort_at,
                         input logic [63:0] pc0);
    int          id;
    logic [63:0] pc_cap;
    id            = lowest_set(irq);
    irq_in        = irq;
    irq_enable_in = 1'b1;
    mret_in       = 1'b0;
    stall_in      = 1'b0;
    pc_in         = pc0 ^ 64'hFFFF;
    pc_cap        = '0;
    step();
    for (int c = 0; c <= stall_len; c++) begin
      expect_out("drain", 1, 1, 0, 0, 0, 0, '0, 0, 1);
      if (noise) drive_noise();
      mret_in  = noise ? 1'($urandom) : 1'b0;
      stall_in = (c < stall_len);
      pc_in    = (c == stall_len) ? pc0 : {$urandom, $urandom};
      pc_cap   = pc_in;
      step();
    end
    m_mepc   = pc_cap;
    m_mcause = {1'b1, 59'b0, 4'(id)};
    for (int k = 1; k <= NUM_SAVE; k++) begin
      expect_out("save", 0, 1, 1, 0, k, 0, '0, 0, 1);
      if (k == abort_at) begin
        rst_in = 1'b1;
        step();
        rst_in   = 1'b0;
        m_mepc   = '0;
        m_mcause = '0;
        expect_idle("abort");
        return;
      end
      if (noise) drive_noise(); else stall_in = 1'($urandom);
      step();
    end
    expect_out("vector", 0, 0, 0, 0, 0, 1, VB + 64'(4 * id), 1 << id, 1);
    if (noise) drive_noise();
    mret_in = 1'b0;
    step();
    for (int h = 0; h <= handler_len; h++) begin
      expect_out("handler", 0, 0, 0, 0, 0, 0, '0, 0, 1);
      if (noise) drive_noise(); else stall_in = 1'($urandom);
      mret_in = (h == handler_len);
      step();
    end
    for (int k = 1; k <= NUM_SAVE; k++) begin
      expect_out("restore", (k == 1), 1, 0, 1, k, 0, '0, 0, 1);
      if (noise) drive_noise(); else mret_in = 1'b0;
      step();
    end
    expect_out("resume", 0, 0, 0, 0, 0, 1, m_mepc, 0, 1);
    step();
    expect_idle("idle_after");
  endtask

  initial begin
    rst_in        = 1'b1;
    irq_in        = '0;
    irq_enable_in = 1'b0;
    mret_in       = 1'b0;
    stall_in      = 1'b0;
    pc_in         = '0;
    step();
    step();
    expect_idle("reset");
    rst_in = 1'b0;
    step();
    expect_idle("post_reset");

    // Basic entry/return, id 2 from 4'b0100 at pc 0x2000.
    run_irq(4'b0100, 0, 2, 1'b0, 0, 64'h2000);
    check("t1.mepc",   csr_mepc_out, 64'h2000);
    check("t1.mcause", mcause_out,   64'h8000_0000_0000_0002);

    // mret in IDLE is ignored.
    irq_in  = '0;
    mret_in = 1'b1;
    step();
    mret_in = 1'b0;
    expect_idle("mret_idle");

    // Lowest index wins; request changes afterwards do not alter the id.
    run_irq(4'b1010, 0, 1, 1'b1, 0, 64'h3000);
    check("t2.mcause", mcause_out, 64'h8000_0000_0000_0001);

    // Drain held five cycles by downstream stall.
    run_irq(4'b0001, 5, 0, 1'b0, 0, 64'h4440);

    // Request held through handler: no nesting, retaken after one IDLE cycle.
    run_irq(4'b0001, 0, 4, 1'b0, 0, 64'h5000);
    run_irq(4'b0001, 0, 0, 1'b0, 0, 64'h5004);

    // Reset at save address 10 aborts the sequence.
    run_irq(4'b1000, 1, 0, 1'b1, 10, 64'h6000);
    irq_in        = 4'hF;
    irq_enable_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_idle("disabled");
    end

    for (int t = 0; t < 12; t++) begin
      run_irq(NUM_IRQ'($urandom_range(1, 15)), $urandom_range(0, 4),
              $urandom_range(0, 5), 1'b1, 0, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
